fetch_stage: RTL
================

# fetch_stage

Fetch stage and IF/ID pipeline register of the five-stage core. Holds the PC, presents it to instruction memory, and latches the fetched word into IF/ID. It consumes the hazard unit's `NOP` and `PcStall` decisions and the execute stage's branch/jump redirect. It also latches HALT so fetch stops cleanly.

## Interface
- `NOP_INSTR`, 16'h0800: encoding of the NOP instruction (opcode 00001) loaded into IF/ID as a bubble.
- `RESET_PC`, 16'h0000: PC value after reset.

Ports:
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst`  in  1: reset. Synchronous and active-low: `rst`=0 at a rising edge resets the block.
- `NOP`  in  1: hazard unit requests a bubble into IF/ID this cycle.
- `PcStall`  in  1: hazard unit requests the PC to hold this cycle.
- `redirect`  in  1: taken branch or jump resolved downstream.
- `redirect_pc`  in  16: target PC when `redirect`=1.
- `imem_rdy`  in  1: instruction memory data is valid this cycle.
- `imem_data`  in  16: instruction word at `imem_addr`. Combinational read.
- `imem_addr`  out  16: current PC, driven directly from the PC register.
- `id_instr`  out  16: IF/ID instruction.
- `id_pc2`  out  16: IF/ID PC+2 of `id_instr`.
- `id_valid`  out  1: IF/ID holds a real instruction. 0 means it holds a bubble.
- `halted`  out  1: a HALT has been accepted and fetch is frozen.
- `err`  out  1: sticky flag, set when a misaligned redirect target is seen.

## Operation
- `pc_next` = PC + 2, using 16-bit modular arithmetic. 16'hFFFE wraps to 16'h0000.
- `accept` = `imem_rdy` & ~`NOP` & ~`PcStall` & ~`redirect` & ~`halted`.
- `is_halt` = (`imem_data[15:11]` == 5'b00000).
- PC update, in priority order:
  1. Reset: PC ← `RESET_PC`.
  2. `redirect`: PC ← {`redirect_pc[15:1]`, 1'b0}.
  3. `halted`: PC holds.
  4. `PcStall` or ~`imem_rdy`: PC holds.
  5. `accept` & `is_halt`: PC holds.
  6. Otherwise (`accept`): PC ← `pc_next`.
  7. Any remaining case (`NOP`=1, `PcStall`=0, `imem_rdy`=1): PC ← `pc_next`. This case is the one-cycle branch-shadow bubble; the fetched word is dropped and the fall-through advances.
- IF/ID update:
  - If `accept`: `id_instr` ← `imem_data`, `id_pc2` ← `pc_next`, `id_valid` ← 1.
  - Otherwise: `id_instr` ← `NOP_INSTR`, `id_valid` ← 0, and `id_pc2` holds.
  - IF/ID always loads; the block has no IF/ID hold mode. A hazard stall is realised as bubble plus PC hold plus re-fetch.
- Halt latch:
  - Set when `accept` & `is_halt`. The HALT word itself enters IF/ID with `id_valid`=1.
  - Cleared by reset or by `redirect`, because a HALT fetched behind a taken branch is wrong-path.
- Error latch: `err` is set when `redirect` & `redirect_pc[0]`. It is cleared only by reset.
- Simultaneous events:
  - `redirect` beats everything: the word fetched that cycle is squashed, even if it is a HALT.
  - `NOP` with `PcStall`: bubble and PC hold, the normal RAW stall.
  - `PcStall` without `NOP`: PC holds and IF/ID still gets a bubble, because `accept`=0.

## Timing
- Reset values: PC = `RESET_PC`, `imem_addr` = 16'h0000, `id_instr` = `NOP_INSTR`, `id_pc2` = 16'h0000, `id_valid` = 0, `halted` = 0, `err` = 0.
- Reset asserted mid-stream wins over every other input on that edge. The cycle after deassertion fetches `RESET_PC`.
- Fetch latency: the instruction at PC appears on `id_instr` one edge after `imem_rdy`=1 with `accept`.
- Redirect: `imem_addr` equals the target one edge after `redirect`=1. The target instruction reaches `id_instr` one edge later. There is exactly one bubble.
- `imem_rdy` low for N cycles inserts N bubbles and holds PC for N cycles. No word is lost.
- `halted` rises on the same edge that loads the HALT into IF/ID. From then on `id_valid`=0 every cycle.

## Test plan
- Reset then free-run, with `imem_rdy`=1, no hazards, and imem returning 16'h4000 | addr: `id_pc2` shows 0x0002, 0x0004, 0x0006 on successive edges, and `id_valid`=1 throughout.
- `NOP`=`PcStall`=1 for 2 cycles at PC=0x0010: `imem_addr` stays 0x0010 for 3 cycles and `id_instr`=0x0800 twice with `id_valid`=0. Then the word at 0x0010 enters with `id_pc2`=0x0012.
- `redirect`=1, `redirect_pc`=0x0100, same cycle as `NOP`=1: next `imem_addr`=0x0100 and IF/ID holds a bubble. The next edge gives `id_pc2`=0x0102.
- Fetch 16'h0000 at PC=0x0020: `halted`=1, `imem_addr` frozen at 0x0020, and `id_valid`=0 afterwards. Then `redirect` to 0x0040 clears `halted` and fetch resumes at 0x0040.
- `imem_rdy` low 3 cycles at PC=0xFFFE, then high: three bubbles, then 0xFFFE is accepted and the next `imem_addr`=0x0000 (wrap).
- `redirect_pc`=0x0033: `err`=1 (sticky) and `imem_addr`=0x0032. Assert `rst`=0 mid-run: every output returns to its reset value on that edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Fetch-stage bundle covering hazard/redirect controls, the
//             instruction-memory port and the IF/ID register outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
    // Hazard unit and execute-stage redirect
    logic        NOP;
    logic        PcStall;
    logic        redirect;
    logic [15:0] redirect_pc;

    // Instruction memory
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] imem_addr;

    // IF/ID register and status
    logic [15:0] id_instr;
    logic [15:0] id_pc2;
    logic        id_valid;
    logic        halted;
    logic        err;

    modport master (
        input  NOP, PcStall, redirect, redirect_pc, imem_rdy, imem_data,
        output imem_addr, id_instr, id_pc2, id_valid, halted, err
    );

    modport slave (
        output NOP, PcStall, redirect, redirect_pc, imem_rdy, imem_data,
        input  imem_addr, id_instr, id_pc2, id_valid, halted, err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC register, instruction fetch and IF/ID pipeline register
//             with hazard bubbles, redirect, HALT freeze and misalign flag.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] NOP_INSTR = 16'h0800,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_stage_if.master fs
);

    localparam logic [4:0]  c_halt_opcode = 5'b00000;
    localparam logic [15:0] c_pc_step     = 16'd2;

    logic [15:0] r_pc;
    logic [15:0] r_id_instr;
    logic [15:0] r_id_pc2;
    logic        r_id_valid;
    logic        r_halted;
    logic        r_err;

    logic [15:0] w_pc_next;
    logic        w_accept;
    logic        w_is_halt;
    logic [15:0] w_redirect_target;

    assign w_pc_next         = r_pc + c_pc_step;
    assign w_accept          = fs.imem_rdy & ~fs.NOP & ~fs.PcStall
                             & ~fs.redirect & ~r_halted;
    assign w_is_halt         = (fs.imem_data[15:11] == c_halt_opcode);
    assign w_redirect_target = {fs.redirect_pc[15:1], 1'b0};

    // PC: redirect wins; a NOP without stall still advances (branch shadow)
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else if (fs.redirect) begin
            r_pc <= w_redirect_target;
        end else if (r_halted) begin
            r_pc <= r_pc;
        end else if (fs.PcStall || !fs.imem_rdy) begin
            r_pc <= r_pc;
        end else if (w_accept && w_is_halt) begin
            r_pc <= r_pc;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID loads every cycle: real word on accept, otherwise a bubble
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_id_instr <= NOP_INSTR;
            r_id_pc2   <= 16'h0000;
            r_id_valid <= 1'b0;
        end else if (w_accept) begin
            r_id_instr <= fs.imem_data;
            r_id_pc2   <= w_pc_next;
            r_id_valid <= 1'b1;
        end else begin
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end
    end

    // A HALT behind a taken branch is wrong-path, so redirect clears it
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_halted <= 1'b0;
        end else if (fs.redirect) begin
            r_halted <= 1'b0;
        end else if (w_accept && w_is_halt) begin
            r_halted <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (fs.redirect && fs.redirect_pc[0]) begin
            r_err <= 1'b1;
        end
    end

    assign fs.imem_addr = r_pc;
    assign fs.id_instr  = r_id_instr;
    assign fs.id_pc2    = r_id_pc2;
    assign fs.id_valid  = r_id_valid;
    assign fs.halted    = r_halted;
    assign fs.err       = r_err;

endmodule
`default_nettype wire
